// File: rtl/ifu.sv
// rtl/ifu.sv - single-issue, non-speculative instruction fetch unit with valid/ready hand-off to execute
// Optional misaligned-dnpc trap is enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  input  logic            dnpc_valid,
  input  logic [XLEN-1:0] dnpc,
  input  logic            halt,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RESP   = 3'd2,
    S_HOLD   = 3'd3,
    S_WAITPC = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            xfer;
  logic            take_pc;
  logic            misalign;
  logic [XLEN-1:0] pc_nxt;

  assign xfer = (state == S_HOLD) && inst_ready;

  // halt beats dnpc_valid, so a next PC is only taken when execute is not stopping.
  assign take_pc = (xfer || (state == S_WAITPC)) && dnpc_valid && !halt;

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_q;

  assign misalign    = take_pc && (dnpc[1:0] != 2'b00);
  assign pc_nxt      = dnpc;
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (misalign) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign misalign    = 1'b0;
  assign pc_nxt      = dnpc & {{(XLEN-2){1'b1}}, 2'b00};
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (imem_resp_valid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (xfer) begin
          if (halt)            state_nxt = S_HALT;
          else if (dnpc_valid) state_nxt = misalign ? S_HALT : S_REQ;
          else                 state_nxt = S_WAITPC;
        end
      end
      S_WAITPC: begin
        if (halt)            state_nxt = S_HALT;
        else if (dnpc_valid) state_nxt = misalign ? S_HALT : S_REQ;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    imem_req_addr  = pc;
    case (state)
      S_REQ:   imem_req_valid = 1'b1;
      S_HOLD:  inst_valid     = 1'b1;
      default: ;
    endcase
  end

  // Responses outside RESP are stray and must not disturb the presented instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      inst <= '0;
    end else begin
      if ((state == S_RESP) && imem_resp_valid) inst <= imem_resp_data;
      if (take_pc) pc <= pc_nxt;
    end
  end

endmodule
